// File: rtl/if_stage_if.sv
// Bundles the fetch-stage control, redirect, imem-load and IF/ID output signals.
// The slave modport is the fetch stage; the master modport is the driving side.
interface if_stage_if;
    logic        i_start;
    logic        i_stall;
    logic        i_pc_src;
    logic [31:0] i_beq_jump_dir;
    logic        i_jump;
    logic [25:0] i_jump_addr;
    logic        i_imem_we;
    logic [7:0]  i_imem_addr;
    logic [31:0] i_imem_wdata;
    logic [31:0] o_instruction;
    logic [31:0] o_pc_plus_4;
    logic        o_valid;
    logic [31:0] o_pc;
    logic        o_halted;
    logic [1:0]  o_state;

    // Handshake: no valid/ready pair. Inputs are sampled on every rising
    // clock edge. o_valid qualifies the IF/ID contents for the ID stage, and
    // i_stall is the only back-pressure signal.
    modport slave (
        input  i_start, i_stall, i_pc_src, i_beq_jump_dir, i_jump, i_jump_addr,
               i_imem_we, i_imem_addr, i_imem_wdata,
        output o_instruction, o_pc_plus_4, o_valid, o_pc, o_halted, o_state
    );

    modport master (
        output i_start, i_stall, i_pc_src, i_beq_jump_dir, i_jump, i_jump_addr,
               i_imem_we, i_imem_addr, i_imem_wdata,
        input  o_instruction, o_pc_plus_4, o_valid, o_pc, o_halted, o_state
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, 256x32 instruction memory and IF/ID register.
// Optional macro IF_HALT_DETECT_EN makes a fetched 0xFFFFFFFF halt the stage.
module if_stage (
    input  logic        i_clk,
    input  logic        i_reset,
    if_stage_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] imem_q [256];
    logic [31:0] fetch_word;
    logic        halt_hit;

    // The PC wraps through address truncation: only bits [9:2] select a word.
    assign fetch_word = imem_q[pc_q[9:2]];

`ifdef IF_HALT_DETECT_EN
    assign halt_hit     = (fetch_word == 32'hFFFF_FFFF);
    assign bus.o_halted = (state_q == ST_HALTED);
`else
    assign halt_hit     = 1'b0;
    assign bus.o_halted = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                instr_d = 32'h0;
                valid_d = 1'b0;
                if (bus.i_start) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Stall has priority over a redirect; a redirect has priority over a halt.
                if (!bus.i_stall) begin
                    if (bus.i_pc_src) begin
                        pc_d    = bus.i_beq_jump_dir;
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                    end else if (bus.i_jump) begin
                        pc_d    = {pcp4_q[31:28], bus.i_jump_addr, 2'b00};
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                    end else if (halt_hit) begin
                        instr_d = 32'h0;
                        valid_d = 1'b0;
                        state_d = ST_HALTED;
                    end else begin
                        instr_d = fetch_word;
                        pcp4_d  = pc_q + 32'd4;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end
            end
            ST_HALTED: begin
                instr_d = 32'h0;
                valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            pc_q    <= 32'h0;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    // Memory contents survive reset; loading is only possible while idle.
    always_ff @(posedge i_clk) begin
        if (i_reset && (state_q == ST_IDLE) && bus.i_imem_we) begin
            imem_q[bus.i_imem_addr] <= bus.i_imem_wdata;
        end
    end

    assign bus.o_instruction = instr_q;
    assign bus.o_pc_plus_4   = pcp4_q;
    assign bus.o_valid       = valid_q;
    assign bus.o_pc          = pc_q;
    assign bus.o_state       = state_q;
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have i_clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have i_reset  in  1  synchronous, active-low reset (low = reset).
REQ-003 SHALL have i_start  in  1  leave IDLE and begin fetching.
REQ-004 SHALL have i_stall  in  1  hazard-unit stall from ID; hold PC and IF/ID.
REQ-005 SHALL have i_pc_src  in  1  branch taken, resolved in ID.
REQ-006 SHALL have i_beq_jump_dir  in  32  branch target from ID.
REQ-007 SHALL have i_jump  in  1  J-type jump decoded in ID.
REQ-008 SHALL have i_jump_addr  in  26  J-type target field (instr[25:0] in ID).
REQ-009 SHALL have i_imem_we, i_imem_addr, i_imem_wdata  in  1/8/32  instruction-memory load port (word address).
REQ-010 SHALL have o_instruction  out  32  IF/ID instruction register (0x00000000 = NOP bubble).
REQ-011 SHALL have o_pc_plus_4  out  32  IF/ID PC+4 register.
REQ-012 SHALL have o_valid  out  1  IF/ID holds a fetched (non-bubble) instruction.
REQ-013 SHALL have o_pc  out  32  current PC; o_halted  out  1  HALTED state flag.

Function
REQ-014 SHALL contain a 256x32 instruction memory, asynchronous read at pc[9:2], synchronous write; PC wraps via address truncation (0x400 reads word 0).
REQ-015 SHALL implement states IDLE, RUN, HALTED; IDLE->RUN on i_start; RUN->HALTED on halt fetch (REQ-020); HALTED exits only by reset.
REQ-016 IDLE: PC holds; IF/ID loads NOP, o_valid=0; imem writes accepted; i_start and write in same cycle both take effect.
REQ-017 RUN, i_stall=1: PC, o_instruction, o_pc_plus_4, o_valid hold; i_pc_src/i_jump ignored; stall has priority over redirect.
REQ-018 RUN, i_stall=0, no redirect: IF/ID <= {pc+4, imem[pc]}, o_valid=1, PC <= PC+4 (mod 2^32); one-cycle fetch latency.
REQ-019 RUN, i_stall=0, redirect: PC <= i_beq_jump_dir if i_pc_src, else {o_pc_plus_4[31:28], i_jump_addr, 2'b00} if i_jump (i_pc_src wins when both); IF/ID <= NOP, o_valid=0 (wrong-path flush).
REQ-020 RUN, i_stall=0, no redirect, imem[pc]==0xFFFFFFFF: IF/ID <= NOP, o_valid=0, PC holds, go HALTED; redirect in the same cycle wins and state stays RUN.
REQ-021 HALTED: PC holds, IF/ID loads NOP each cycle, o_valid=0, o_halted=1; i_stall, redirects, i_start ignored.
REQ-022 imem writes in RUN or HALTED SHALL be ignored.

Reset
REQ-023 While i_reset=0 at an edge: PC=0, o_instruction=0, o_pc_plus_4=0, o_valid=0, o_halted=0, state=IDLE; all other inputs ignored.
REQ-024 Reset mid-RUN/HALTED SHALL take effect at the next edge; imem contents SHALL NOT be reset.

Configuration
REQ-025 Macro IF_HALT_DETECT_EN defined: REQ-020/021 active.
REQ-026 Macro IF_HALT_DETECT_EN undefined: HALTED unreachable, 0xFFFFFFFF fetched as ordinary instruction (o_valid=1), o_halted tied 0.

Verification
REQ-027 Load imem[0..2]=0x20010005,0x20020007,0x00221820; start; no stall -> o_instruction sequence 0x20010005,0x20020007,0x00221820 with o_pc_plus_4 4,8,12, o_valid=1.
REQ-028 At PC=8 assert i_stall 2 cycles -> o_pc=8 and IF/ID unchanged for 2 cycles, then fetch resumes at 8.
REQ-029 i_pc_src=1, i_beq_jump_dir=0x40 -> next o_instruction=0, o_valid=0, o_pc=0x40; following cycle o_instruction=imem[16].
REQ-030 i_jump=1, i_jump_addr=0x0000010, o_pc_plus_4=0x8 -> o_pc=0x40, IF/ID flushed; i_pc_src=1 simultaneously with target 0x80 -> o_pc=0x80.
REQ-031 imem[3]=0xFFFFFFFF with IF_HALT_DETECT_EN -> o_halted=1 next cycle, o_pc=12 frozen, NOPs forever; i_reset=0 one cycle -> o_pc=0, state IDLE, imem retained.
REQ-032 Imem write attempted during RUN to word 5 -> later fetch of word 5 returns original value.
